button_event_rx: RTL

BUTTON_EVENT_RX -- requirements
Module: button_event_rx

---
 rtl/btn_pkg.sv | 18 +
 rtl/button_event_rx_if.sv | 29 ++
 rtl/btn_debounce.sv | 69 ++++++
 rtl/button_event_rx.sv | 97 +++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared constants for the push-button event receiver.
package btn_pkg;

    // Number of push-button channels in the default build.
    localparam int N_BTN_DEFAULT    = 5;

    // Width of the event index presented to the consumer.
    localparam int EVT_ID_W         = 3;

    // Stable cycles needed to accept a level change: 10 ms at 25 MHz.
    localparam int DEBOUNCE_DEFAULT = 250000;

    // Counter width able to hold 0 .. cycles-1 (at least one bit).
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/button_event_rx_if.sv
// Press-event handshake between the button receiver and its consumer.
// The receiver drives the event and the sticky overrun flag; the consumer
// answers with ready and may clear the overrun flag.
interface button_event_rx_if;
    import btn_pkg::*;

    logic                evt_valid;
    logic                evt_ready;
    logic [EVT_ID_W-1:0] evt_id;
    logic                evt_overrun;
    logic                overrun_clr;

    modport master (
        output evt_valid,
        output evt_id,
        output evt_overrun,
        input  evt_ready,
        input  overrun_clr
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        input  evt_overrun,
        output evt_ready,
        output overrun_clr
    );

endinterface

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchronizer, stability counter, accepted
// level and a registered one-cycle pulse on each accepted press.
// The accepted level is held in raw polarity (1 = released) so that reset
// and the synchronizer share the same "released" value.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic btn_level,
    output logic press_pulse
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q,  sync1_d;
    logic             sync2_q,  sync2_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             stable_q, stable_d;
    logic             level_q,  level_d;
    logic             pulse_q,  pulse_d;

    // Next-state: synchronize, count disagreeing cycles, accept after a full run.
    always_comb begin
        sync1_d  = btn_n;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Output level follows the accepted level one cycle later; the pulse
        // is aligned with the first cycle that level reads pressed.
        level_d = ~stable_q;
        pulse_d = ~stable_q & ~level_q;
    end

    // Channel state register; everything returns to "released" on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            cnt_q    <= '0;
            stable_q <= 1'b1;
            level_q  <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            level_q  <= level_d;
            pulse_q  <= pulse_d;
        end
    end

    assign btn_level   = level_q;
    assign press_pulse = pulse_q;

endmodule

// File: rtl/button_event_rx.sv
// Debounced push-button receiver. Each channel is debounced separately;
// accepted presses are queued as one pending bit per button and handed to
// the consumer lowest index first through a valid/ready output stage.
// N_BTN must not exceed 2**EVT_ID_W so every index fits in evt_id.
module button_event_rx
    import btn_pkg::*;
#(
    parameter int N_BTN           = N_BTN_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_BTN-1:0]   btn_n,
    output logic [N_BTN-1:0]   btn_level,
    output logic [N_BTN-1:0]   press_pulse,
    button_event_rx_if.master  evt
);

    logic [N_BTN-1:0]    pend_q,  pend_d;
    logic                valid_q, valid_d;
    logic [EVT_ID_W-1:0] id_q,    id_d;
    logic                ovr_q,   ovr_d;

    logic                stage_free;
    logic                load;
    logic [EVT_ID_W-1:0] load_idx;
    logic [N_BTN-1:0]    load_mask;
    logic                ovr_set;

    // Lowest set index of a pending vector, zero-extended to the id width.
    function automatic logic [EVT_ID_W-1:0] lowest_index(input logic [N_BTN-1:0] vec);
        logic [EVT_ID_W-1:0] idx;
        idx = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = EVT_ID_W'(i);
            end
        end
        return idx;
    endfunction

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk         (clk),
            .reset       (reset),
            .btn_n       (btn_n[g]),
            .btn_level   (btn_level[g]),
            .press_pulse (press_pulse[g])
        );
    end

    // Arbitration, output-stage loading, pending update and overrun tracking.
    always_comb begin
        stage_free = ~valid_q | evt.evt_ready;
        load       = stage_free & (|pend_q);
        load_idx   = lowest_index(pend_q);
        load_mask  = load ? (N_BTN'(1) << load_idx) : '0;

        valid_d = valid_q;
        id_d    = id_q;
        if (stage_free) begin
            valid_d = load;
            if (load) begin
                id_d = load_idx;
            end
        end

        // A press landing on the bit being loaded this cycle re-arms it
        // without counting as lost; any other press on a set bit is merged
        // and flagged.
        pend_d  = (pend_q & ~load_mask) | press_pulse;
        ovr_set = |(press_pulse & pend_q & ~load_mask);
        ovr_d   = ovr_set | (ovr_q & ~evt.overrun_clr);
    end

    // Event state register; reset discards queued and presented events.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q  <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            ovr_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            ovr_q   <= ovr_d;
        end
    end

    assign evt.evt_valid   = valid_q;
    assign evt.evt_id      = id_q;
    assign evt.evt_overrun = ovr_q;

endmodule
